// File: rtl/ex_mem_stage_reg.sv
// rtl/ex_mem_stage_reg.sv - EX/MEM pipeline register with handshake, flush and forwarding tap
// Optional stall/bubble counters enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [CTRL_W-1:0]     i_ctrl,
    input  logic [DATA_W-1:0]     i_alu_result,
    input  logic [DATA_W-1:0]     i_write_data,
    input  logic [REG_ADDR_W-1:0] i_write_reg,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_mem_ready,
    output logic                  o_valid,
    output logic [CTRL_W-1:0]     o_ctrl,
    output logic [DATA_W-1:0]     o_alu_result,
    output logic [DATA_W-1:0]     o_write_data,
    output logic [REG_ADDR_W-1:0] o_write_reg,
    output logic                  o_fwd_valid
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]           o_stall_cnt,
    output logic [31:0]           o_bubble_cnt
`endif
);

    logic                  valid_q, valid_d;
    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [DATA_W-1:0]     alu_q, alu_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic                  adv;

    // An empty stage refills regardless of MEM backpressure.
    assign adv     = !i_stall && (!valid_q || i_mem_ready);
    assign o_ready = adv;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;
        wdata_d = wdata_q;
        wreg_d  = wreg_q;
        if (i_flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (adv) begin
            valid_d = i_valid;
            ctrl_d  = i_valid ? i_ctrl : '0;
            alu_d   = i_alu_result;
            wdata_d = i_write_data;
            wreg_d  = i_write_reg;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            alu_q   <= '0;
            wdata_q <= '0;
            wreg_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            wreg_q  <= wreg_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_ctrl       = ctrl_q & {CTRL_W{valid_q}};
    assign o_alu_result = alu_q;
    assign o_write_data = wdata_q;
    assign o_write_reg  = wreg_q;
    assign o_fwd_valid  = valid_q && ctrl_q[CTRL_W-1] && (wreg_q != '0);

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic        stall_evt, bubble_evt;

    assign stall_evt  = valid_q && !adv && !i_flush;
    assign bubble_evt = i_flush || (adv && !i_valid);

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign o_stall_cnt  = stall_cnt_q;
    assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule
